uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 framing with parity checking.
// The rx line is double-synchronized, and every decision is taken on the synchronized copy.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [5:0] {
        IDLE      = 6'b000001,
        START     = 6'b000010,
        DATA      = 6'b000100,
        PARITY    = 6'b001000,
        STOP      = 6'b010000,
        WAIT_HIGH = 6'b100000
    } state_t;
`else
    typedef enum logic [4:0] {
        IDLE      = 5'b00001,
        START     = 5'b00010,
        DATA      = 5'b00100,
        STOP      = 5'b01000,
        WAIT_HIGH = 5'b10000
    } state_t;
`endif

    state_t      state_q;
    logic        rx_meta_q, rx_s_q;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  idx_q;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_out_q;
    logic        valid_q, frame_err_q, busy_q;

`ifdef UART_RX_PARITY_EN
    logic        parity_err_q;
    logic        par_ok_q;

    // Even parity: the parity bit equals the XOR of the eight data bits.
    function automatic logic parity_ok(input logic [7:0] d, input logic p);
        return p == (^d);
    endfunction
`endif

    always_comb begin
        timer_d        = timer_q + 16'd1;
        shift_d        = shift_q;
        shift_d[idx_q] = rx_s_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= IDLE;
            timer_q      <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
            par_ok_q     <= 1'b0;
`endif
        end else begin
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= START;
                        timer_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                // Mid-start-bit check rejects glitches shorter than half a bit.
                START: begin
                    if (timer_q == HALF_M1) begin
                        timer_q <= '0;
                        if (!rx_s_q) begin
                            state_q <= DATA;
                            idx_q   <= '0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                DATA: begin
                    if (timer_q == FULL_M1) begin
                        shift_q <= shift_d;
                        timer_q <= '0;
                        idx_q   <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end else begin
                        timer_q <= timer_d;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (timer_q == FULL_M1) begin
                        par_ok_q <= parity_ok(shift_q, rx_s_q);
                        timer_q  <= '0;
                        state_q  <= STOP;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
`endif
                STOP: begin
                    if (timer_q == FULL_M1) begin
                        timer_q <= '0;
                        if (rx_s_q) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (par_ok_q) begin
                                data_out_q <= shift_q;
                                valid_q    <= 1'b1;
                            end else begin
                                parity_err_q <= 1'b1;
                            end
`else
                            data_out_q <= shift_q;
                            valid_q    <= 1'b1;
`endif
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_HIGH;
                        end
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                // Hold off after a broken stop bit until the line returns to idle.
                WAIT_HIGH: begin
                    if (rx_s_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    timer_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out  = data_out_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at 16 clocks per bit; follows UART_RX_PARITY_EN when defined.
module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       valid, frame_err, parity_err, busy;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    int valid_cnt = 0, ferr_cnt = 0, perr_cnt = 0, multi_cnt = 0;
    logic [7:0] vdata[$];
    int         vcyc[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data_out  (data_out),
        .valid     (valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            valid_cnt++;
            vdata.push_back(data_out);
            vcyc.push_back(cyc);
        end
        if (frame_err === 1'b1) ferr_cnt++;
        if (parity_err === 1'b1) perr_cnt++;
        if (int'(valid) + int'(frame_err) + int'(parity_err) > 1) multi_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        idle(CPB);
    endtask

    // par_flip inverts the otherwise-correct even parity bit (parity builds only).
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^b) ^ par_flip);
`else
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        send_bit(stop_bit);
        rx = 1'b1;
    endtask

    task automatic check_counts(input string tag, input int v0, input int f0, input int p0,
                                input int v_exp, input int f_exp, input int p_exp);
        check_eq({tag, "_valid"}, valid_cnt - v0, v_exp);
        check_eq({tag, "_ferr"}, ferr_cnt - f0, f_exp);
        check_eq({tag, "_perr"}, perr_cnt - p0, p_exp);
    endtask

    initial begin
        int v0, f0, p0, n0, gap;

        // Reset state
        idle(4);
        check_eq("rst_data", data_out, 8'h00);
        check_eq("rst_valid", valid, 1'b0);
        check_eq("rst_ferr", frame_err, 1'b0);
        check_eq("rst_perr", parity_err, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        reset = 1'b0;
        idle(10);

        // Clean 0x55
        v0 = valid_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        send_byte(8'h55, 1'b1, 1'b0);
        idle(20);
        check_counts("b55", v0, f0, p0, 1, 0, 0);
        check_eq("b55_data", data_out, 8'h55);
        check_eq("b55_busy", busy, 1'b0);

        // Short low glitch is rejected
        v0 = valid_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        rx = 1'b0;
        idle(4);
        check_eq("glitch_busy_hi", busy, 1'b1);
        rx = 1'b1;
        idle(10);
        check_eq("glitch_busy_lo", busy, 1'b0);
        check_counts("glitch", v0, f0, p0, 0, 0, 0);

        // Broken stop bit, then recovery
        v0 = valid_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        send_byte(8'hA3, 1'b0, 1'b0);
        idle(20);
        check_counts("ferr", v0, f0, p0, 0, 1, 0);
        check_eq("ferr_data_hold", data_out, 8'h55);
        check_eq("ferr_busy", busy, 1'b0);
        v0 = valid_cnt;
        send_byte(8'h3C, 1'b1, 1'b0);
        idle(20);
        check_eq("b3c_valid", valid_cnt - v0, 1);
        check_eq("b3c_data", data_out, 8'h3C);

        // Reset in the middle of 0xF0 (during data bit 4)
        v0 = valid_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        rx = 1'b1;
        idle(8);
        reset = 1'b1;
        idle(2);
        check_eq("midrst_data", data_out, 8'h00);
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_pulses", {29'd0, valid, frame_err, parity_err}, 32'd0);
        idle(CPB * 4);
        reset = 1'b0;
        idle(20);
        check_counts("midrst", v0, f0, p0, 0, 0, 0);
        check_eq("postrst_busy", busy, 1'b0);
        send_byte(8'h81, 1'b1, 1'b0);
        idle(20);
        check_eq("b81_valid", valid_cnt - v0, 1);
        check_eq("b81_data", data_out, 8'h81);

        // Back-to-back 0x00, 0xFF with a single stop bit
        v0 = valid_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        n0 = vdata.size();
        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b0);
        idle(20);
        check_counts("b2b", v0, f0, p0, 2, 0, 0);
        if (vdata.size() >= n0 + 2) begin
            gap = vcyc[n0 + 1] - vcyc[n0];
            check_eq("b2b_gap", (gap >= FRAME_BITS * CPB - 1 && gap <= FRAME_BITS * CPB + 1)
                                ? FRAME_BITS * CPB : gap, FRAME_BITS * CPB);
            check_eq("b2b_first", vdata[n0], 8'h00);
            check_eq("b2b_second", vdata[n0 + 1], 8'hFF);
        end
        check_eq("b2b_last", data_out, 8'hFF);

`ifdef UART_RX_PARITY_EN
        // 0x07 has odd weight: correct even parity bit is 1
        v0 = valid_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        send_byte(8'h07, 1'b1, 1'b1);
        idle(20);
        check_counts("par_bad", v0, f0, p0, 0, 0, 1);
        check_eq("par_bad_data", data_out, 8'hFF);
        v0 = valid_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        send_byte(8'h07, 1'b1, 1'b0);
        idle(20);
        check_counts("par_ok", v0, f0, p0, 1, 0, 0);
        check_eq("par_ok_data", data_out, 8'h07);
`endif

        check_eq("pulse_exclusive", multi_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
